ifm_word_feeder: RTL and testbench

Upstream stage for the IFM parser. Accepts 512-bit input-feature-map words from an AXI-Stream slave into a small FIFO and presents the head word on `fm`. The head advances when the parser raises its word request (`input_req`). When the FIFO runs dry it drives the parser's `stall`, so the parser freezes until the next word lands. One transfer is bounded by a word count latched at `conv_start`.

---
 rtl/ifm_word_feeder.sv | 157 +++++++++++++++
 tb/tb_ifm_word_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_word_feeder.sv
// ifm_word_feeder
// Buffers 512-bit input-feature-map words arriving on an AXI-Stream slave in
// a small FIFO and presents the head word to the IFM parser. The parser pulls
// words with input_req and is frozen through stall whenever the FIFO is empty
// or downstream back-pressure is asserted. A transfer is bounded by the word
// count latched at conv_start, and done pulses once the final word is consumed.
//
// Ports:
//   clk, rst_n         single clock, async active-low reset
//   conv_start         one-cycle transfer start (IDLE only)
//   total_words        words in the transfer, sampled with conv_start
//   s_axis_t*          AXI-Stream slave (tdata/tvalid/tready)
//   fm                 FIFO head word, zero while empty
//   ifm_read           high while a transfer is running (parser enable)
//   input_req          parser request for the next word
//   ds_stall           downstream back-pressure, merged into stall
//   stall              ds_stall or FIFO empty
//   done               one-cycle pulse after the last word is consumed
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for conv_start; stream not accepted, parser disabled
// ST_RUN  | accepting up to total_words beats and feeding the parser
module ifm_word_feeder #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  conv_start,
  input  logic [CNT_W-1:0]      total_words,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] fm,
  output logic                  ifm_read,
  input  logic                  input_req,
  input  logic                  ds_stall,
  output logic                  stall,
  output logic                  done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic push;
  logic pop;

  assign ifm_read      = (state_q == ST_RUN);
  assign stall         = ds_stall | (count_q == '0);
  // Ready is derived only from registered state, so a full FIFO blocks the
  // beat even if the parser pops in the same cycle.
  assign s_axis_tready = ifm_read & (count_q < DEPTH_C) & (acc_cnt_q < total_q);
  assign push          = s_axis_tvalid & s_axis_tready;
  // Parser holds input_req through stalls; gating with stall gives exactly
  // one pop per request.
  assign pop           = input_req & ifm_read & ~stall;
  assign fm            = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign done          = done_q;

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    acc_cnt_d = acc_cnt_q;
    pop_cnt_d = pop_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    done_d    = 1'b0;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      pop_cnt_d = pop_cnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (conv_start) begin
          if (total_words != '0) begin
            state_d   = ST_RUN;
            total_d   = total_words;
            acc_cnt_d = '0;
            pop_cnt_d = '0;
            // Leftovers from an aborted transfer are discarded here.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (pop && (pop_cnt_d == total_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      acc_cnt_q <= '0;
      pop_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      acc_cnt_q <= acc_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Storage is not reset; fm is masked to zero while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_ifm_word_feeder.sv
module tb_ifm_word_feeder;

  localparam int DW    = 512;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          conv_start;
  logic [CW-1:0] total_words;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] fm;
  logic          ifm_read;
  logic          input_req;
  logic          ds_stall;
  logic          stall;
  logic          done;

  ifm_word_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .conv_start(conv_start), .total_words(total_words),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .fm(fm), .ifm_read(ifm_read),
    .input_req(input_req), .ds_stall(ds_stall), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: transfer status plus a queue holding buffered words.
  bit            m_run;
  int            m_total, m_acc, m_pops;
  bit            m_done;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] src_q[$];
  int            dut_push_n, dut_pop_n, dut_done_n;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_run = 0; m_total = 0; m_acc = 0; m_pops = 0; m_done = 0;
    m_q.delete();
    src_q.delete();
  endtask

  task automatic clear_tallies();
    dut_push_n = 0; dut_pop_n = 0; dut_done_n = 0;
  endtask

  task automatic idle_inputs();
    conv_start = 0; s_axis_tvalid = 0; input_req = 0; ds_stall = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_fm", fm, '0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_ifm_read", ifm_read, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 1);
  endtask

  // One clock: check outputs at negedge, then advance the model past posedge.
  task automatic cycle();
    logic [DW-1:0] e_fm;
    bit e_rdy, e_stall, mp, mq;
    @(negedge clk);
    e_rdy   = m_run && (m_q.size() < DEPTH) && (m_acc < m_total);
    e_stall = ds_stall || (m_q.size() == 0);
    e_fm    = (m_q.size() != 0) ? m_q[0] : '0;
    chk("fm", fm, e_fm);
    chk("s_axis_tready", s_axis_tready, e_rdy);
    chk("stall", stall, e_stall);
    chk("ifm_read", ifm_read, m_run);
    chk("done", done, m_done);
    if (s_axis_tvalid && s_axis_tready) dut_push_n++;
    if (input_req && ifm_read && !stall) dut_pop_n++;
    if (done) dut_done_n++;
    mp = s_axis_tvalid && e_rdy;
    mq = input_req && m_run && !e_stall;
    @(posedge clk);
    #1;
    m_done = 0;
    if (!m_run) begin
      if (conv_start) begin
        if (total_words != 0) begin
          m_run = 1; m_total = int'(total_words); m_acc = 0; m_pops = 0;
          m_q.delete();
        end else begin
          m_done = 1;
        end
      end
    end else begin
      if (mq) begin
        void'(m_q.pop_front());
        m_pops++;
        if (m_pops == m_total) begin
          m_run = 0;
          m_done = 1;
        end
      end
      if (mp) begin
        m_q.push_back(s_axis_tdata);
        m_acc++;
      end
    end
    if (mp) void'(src_q.pop_front());
  endtask

  // req modes: 0 none, 1 pulse every 4 cycles, 2 held, 3 random (+stray conv_start)
  task automatic drive(input int vpct, input int rm, input int dspct, input int i);
    s_axis_tvalid = (src_q.size() > 0) && ($urandom_range(99) < vpct);
    s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
    ds_stall      = ($urandom_range(99) < dspct);
    conv_start    = 0;
    case (rm)
      1: input_req = ((i % 4) == 3);
      2: input_req = 1;
      3: begin
        input_req = $urandom_range(1) == 1;
        conv_start = ($urandom_range(19) == 0);
        total_words = CW'($urandom_range(9));
      end
      default: input_req = 0;
    endcase
  endtask

  task automatic run_for(input int n, input int vpct, input int rm, input int dspct);
    for (int i = 0; i < n; i++) begin
      drive(vpct, rm, dspct, i);
      cycle();
    end
  endtask

  task automatic run_done(input int max, input int vpct, input int rm, input int dspct);
    int i;
    i = 0;
    while (m_run && i < max) begin
      drive(vpct, rm, dspct, i);
      cycle();
      i++;
    end
    chk("transfer_timeout", m_run, 0);
    idle_inputs();
    cycle();
    cycle();
  endtask

  task automatic start(input int tw, input int extra);
    src_q.delete();
    for (int i = 0; i < tw + extra; i++) src_q.push_back(rand_word());
    idle_inputs();
    conv_start  = 1;
    total_words = CW'(tw);
    cycle();
    conv_start = 0;
  endtask

  initial begin
    logic [DW-1:0] wa, wb, wc;
    rst_n = 0;
    total_words = '0;
    s_axis_tdata = '0;
    idle_inputs();
    model_reset();
    clear_tallies();
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle();

    // Basic transfer of three recognisable words.
    clear_tallies();
    wa = {(DW/4){4'hA}}; wb = {(DW/4){4'hB}}; wc = {(DW/4){4'hC}};
    start(3, 0);
    src_q.delete();
    src_q.push_back(wa); src_q.push_back(wb); src_q.push_back(wc);
    run_done(60, 100, 1, 0);
    chk("basic_pops", dut_pop_n, 3);
    chk("basic_done_pulses", dut_done_n, 1);

    // Full FIFO: only DEPTH beats land until the parser pops.
    clear_tallies();
    start(6, 2);
    run_for(8, 100, 0, 0);
    chk("full_accepted", dut_push_n, 4);
    run_for(1, 100, 2, 0);
    chk("full_no_push_on_pop", dut_push_n, 4);
    run_for(1, 100, 0, 0);
    chk("full_fifth_beat", dut_push_n, 5);
    run_done(80, 100, 2, 0);
    chk("full_total_accepted", dut_push_n, 6);
    chk("full_pops", dut_pop_n, 6);

    // Starvation with held input_req.
    clear_tallies();
    start(2, 0);
    run_for(1, 100, 0, 0);
    run_for(1, 0, 0, 0);
    run_for(2, 0, 2, 0);
    chk("starve_one_pop", dut_pop_n, 1);
    run_for(1, 100, 2, 0);
    run_for(2, 0, 2, 0);
    chk("starve_two_pops", dut_pop_n, 2);
    idle_inputs();
    cycle();

    // Simultaneous push and pop with two buffered words.
    clear_tallies();
    start(5, 0);
    run_for(2, 100, 0, 0);
    run_for(1, 100, 2, 0);
    chk("simul_push", dut_push_n, 3);
    chk("simul_pop", dut_pop_n, 1);
    run_for(1, 0, 0, 0);
    run_done(60, 100, 2, 0);

    // ds_stall blocks pops.
    clear_tallies();
    start(2, 0);
    run_for(1, 100, 0, 0);
    run_for(3, 0, 2, 100);
    chk("ds_stall_no_pop", dut_pop_n, 0);
    run_done(40, 100, 2, 0);
    chk("ds_stall_pops", dut_pop_n, 2);

    // Zero-word start.
    clear_tallies();
    start(0, 2);
    run_for(3, 100, 0, 0);
    chk("zero_done_pulses", dut_done_n, 1);
    chk("zero_no_push", dut_push_n, 0);

    // Reset mid-transfer.
    clear_tallies();
    start(5, 0);
    run_for(2, 100, 0, 0);
    chk("midrst_pushed", dut_push_n, 2);
    idle_inputs();
    #3;
    rst_n = 0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    clear_tallies();
    start(3, 0);
    run_done(60, 80, 3, 20);
    chk("midrst_restart_pops", dut_pop_n, 3);

    // Randomised transfers.
    for (int t = 0; t < 12; t++) begin
      int tw;
      tw = $urandom_range(9);
      start(tw, $urandom_range(3));
      if (tw == 0) run_for(2, 100, 0, 0);
      else run_done(300, $urandom_range(30, 100), 3, $urandom_range(40));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
